// File: rtl/ssp_rx_ctrl_if.sv
// Signal bundle between the SSP receive controller, the shifter, the RxFIFO and the APB slave.
// The slave modport is the controller's view; master is the view of whatever drives it.
interface ssp_rx_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic              overrun_clr;
  logic              fifo_wr;
  logic [DATA_W-1:0] fifo_wdata;
  logic              fifo_rd;
  logic              pready;
  logic              pslverr;
  logic [LVL_W-1:0]  level;
  logic              flag_empty;
  logic              flag_full;
  logic              rx_intr;
  logic              overrun;
  logic              rx_timeout;

  modport slave (
    input  rx_valid, rx_data, psel, penable, pwrite, overrun_clr,
    output fifo_wr, fifo_wdata, fifo_rd, pready, pslverr, level,
           flag_empty, flag_full, rx_intr, overrun, rx_timeout
  );

  modport master (
    output rx_valid, rx_data, psel, penable, pwrite, overrun_clr,
    input  fifo_wr, fifo_wdata, fifo_rd, pready, pslverr, level,
           flag_empty, flag_full, rx_intr, overrun, rx_timeout
  );
endinterface

// File: rtl/ssp_rx_ctrl.sv
// SSP receive FIFO sequencer: push/pop strobes, one-word hold register, APB read wait states, status.
// Optional idle timeout is built when SSP_RX_TIMEOUT_EN is defined; otherwise rx_timeout is tied 0.
//
// state   | meaning
// IDLE    | waiting for an APB read access phase
// RD_POP  | fifo_rd strobe out for one cycle
// RD_DONE | pready high (pslverr if the FIFO was empty) until penable drops
module ssp_rx_ctrl #(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 4,
  parameter int RX_WATERMARK = 2,
  parameter int TIMEOUT_CYC  = 32
) (
  input logic           pclk_i,
  input logic           clr_b_i,
  ssp_rx_ctrl_if.slave  bus_if
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_POP  = 2'd1,
    RD_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              hold_vld_q, hold_vld_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic              fifo_wr_q, fifo_wr_d;
  logic [DATA_W-1:0] fifo_wdata_q, fifo_wdata_d;
  logic              fifo_rd_q, fifo_rd_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic              overrun_q, overrun_d;
  logic              flag_empty_q, flag_full_q, rx_intr_q;
  logic              rd_access;
  logic              space;
  logic              hold_used;
  logic              ovr_evt;

  assign rd_access = bus_if.psel & bus_if.penable & ~bus_if.pwrite;

  always_ff @(posedge pclk_i) begin
    if (!clr_b_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    fifo_rd_d = 1'b0;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_access) begin
          if (level_q != '0) begin
            state_d   = RD_POP;
            fifo_rd_d = 1'b1;
          end else begin
            state_d   = RD_DONE;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
          end
        end
      end
      RD_POP: begin
        state_d  = RD_DONE;
        pready_d = 1'b1;
      end
      RD_DONE: begin
        if (bus_if.penable) begin
          pready_d  = 1'b1;
          pslverr_d = pslverr_q;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes issued together share the next cycle, so a pop being issued now frees a slot for a push.
  always_comb begin
    fifo_wr_d    = 1'b0;
    fifo_wdata_d = fifo_wdata_q;
    hold_vld_d   = hold_vld_q;
    hold_data_d  = hold_data_q;
    hold_used    = 1'b0;
    ovr_evt      = 1'b0;
    space        = (level_q < LVL_W'(DEPTH)) | fifo_rd_d;

    if (hold_vld_q && space) begin
      fifo_wr_d    = 1'b1;
      fifo_wdata_d = hold_data_q;
      hold_vld_d   = 1'b0;
      hold_used    = 1'b1;
    end

    if (bus_if.rx_valid) begin
      if (space && !hold_used) begin
        fifo_wr_d    = 1'b1;
        fifo_wdata_d = bus_if.rx_data;
      end else if (!hold_vld_d) begin
        hold_vld_d  = 1'b1;
        hold_data_d = bus_if.rx_data;
      end else begin
        ovr_evt = 1'b1;
      end
    end

    case ({fifo_wr_d, fifo_rd_d})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    overrun_d = ovr_evt | (overrun_q & ~bus_if.overrun_clr);
  end

  always_ff @(posedge pclk_i) begin
    if (!clr_b_i) begin
      level_q      <= '0;
      hold_vld_q   <= 1'b0;
      hold_data_q  <= '0;
      fifo_wr_q    <= 1'b0;
      fifo_wdata_q <= '0;
      fifo_rd_q    <= 1'b0;
      pready_q     <= 1'b0;
      pslverr_q    <= 1'b0;
      overrun_q    <= 1'b0;
      flag_empty_q <= 1'b1;
      flag_full_q  <= 1'b0;
      rx_intr_q    <= 1'b0;
    end else begin
      level_q      <= level_d;
      hold_vld_q   <= hold_vld_d;
      hold_data_q  <= hold_data_d;
      fifo_wr_q    <= fifo_wr_d;
      fifo_wdata_q <= fifo_wdata_d;
      fifo_rd_q    <= fifo_rd_d;
      pready_q     <= pready_d;
      pslverr_q    <= pslverr_d;
      overrun_q    <= overrun_d;
      flag_empty_q <= (level_d == '0);
      flag_full_q  <= (level_d == LVL_W'(DEPTH));
      rx_intr_q    <= (level_d >= LVL_W'(RX_WATERMARK));
    end
  end

`ifdef SSP_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;
  logic            rx_timeout_q;

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (fifo_wr_d || fifo_rd_d || (level_d == '0)) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != TO_W'(TIMEOUT_CYC)) begin
      idle_cnt_d = idle_cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge pclk_i) begin
    if (!clr_b_i) begin
      idle_cnt_q   <= '0;
      rx_timeout_q <= 1'b0;
    end else begin
      idle_cnt_q   <= idle_cnt_d;
      rx_timeout_q <= (idle_cnt_d == TO_W'(TIMEOUT_CYC));
    end
  end

  assign bus_if.rx_timeout = rx_timeout_q;
`else
  assign bus_if.rx_timeout = 1'b0;
`endif

  assign bus_if.fifo_wr    = fifo_wr_q;
  assign bus_if.fifo_wdata = fifo_wdata_q;
  assign bus_if.fifo_rd    = fifo_rd_q;
  assign bus_if.pready     = pready_q;
  assign bus_if.pslverr    = pslverr_q;
  assign bus_if.level      = level_q;
  assign bus_if.flag_empty = flag_empty_q;
  assign bus_if.flag_full  = flag_full_q;
  assign bus_if.rx_intr    = rx_intr_q;
  assign bus_if.overrun    = overrun_q;
endmodule

// File: tb/tb_ssp_rx_ctrl.sv
// Bench for ssp_rx_ctrl: directed scenarios with literal expectations, then random traffic
// compared every cycle against an occupancy/hold model derived from the receive rules.
module tb_ssp_rx_ctrl;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int WM     = 2;
  localparam int TO     = 32;

  logic clk   = 1'b0;
  logic clr_b = 1'b0;
  always #5 clk = ~clk;

  ssp_rx_ctrl_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  ssp_rx_ctrl #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .RX_WATERMARK(WM), .TIMEOUT_CYC(TO)
  ) dut (
    .pclk_i (clk),
    .clr_b_i(clr_b),
    .bus_if (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: occupancy count, optional hold word, read transaction tracked by the expected outputs.
  int          m_lvl  = 0;
  bit          m_hv   = 0;
  logic [7:0]  m_hd   = '0;
  bit          m_wr   = 0;
  logic [7:0]  m_wd   = '0;
  bit          m_rd   = 0;
  bit          m_rdy  = 0;
  bit          m_err  = 0;
  bit          m_ovr  = 0;
  bit          m_to   = 0;
  int          m_idle = 0;
  bit          m_live = 0;

  always @(posedge clk) begin : model
    bit acc, pop, sp, lost;
    if (!clr_b) begin
      m_lvl = 0; m_hv = 0; m_wr = 0; m_rd = 0; m_rdy = 0; m_err = 0;
      m_ovr = 0; m_to = 0; m_idle = 0; m_live = 1;
    end else begin
      acc = bus.psel && bus.penable && !bus.pwrite;
      pop = 0;
      if (m_rdy) begin
        if (!bus.penable) begin m_rdy = 0; m_err = 0; end
      end else if (m_rd) begin
        m_rdy = 1;
      end else if (acc) begin
        if (m_lvl > 0) pop = 1;
        else begin m_rdy = 1; m_err = 1; end
      end
      m_rd = pop;
      sp   = (m_lvl < DEPTH) || pop;
      m_wr = 0;
      lost = 0;
      if (m_hv && sp) begin
        m_wr = 1; m_wd = m_hd; m_hv = 0; sp = 0;
      end
      if (bus.rx_valid) begin
        if (sp) begin m_wr = 1; m_wd = bus.rx_data; end
        else if (!m_hv) begin m_hv = 1; m_hd = bus.rx_data; end
        else lost = 1;
      end
      m_lvl = m_lvl + int'(m_wr) - int'(pop);
      if (lost) m_ovr = 1;
      else if (bus.overrun_clr) m_ovr = 0;
`ifdef SSP_RX_TIMEOUT_EN
      if (m_wr || pop || m_lvl == 0) m_idle = 0;
      else if (m_idle < TO) m_idle++;
      m_to = (m_idle == TO);
`endif
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("fifo_wr",    32'(bus.fifo_wr),    32'(m_wr));
      if (m_wr) chk("fifo_wdata", 32'(bus.fifo_wdata), 32'(m_wd));
      chk("fifo_rd",    32'(bus.fifo_rd),    32'(m_rd));
      chk("pready",     32'(bus.pready),     32'(m_rdy));
      chk("pslverr",    32'(bus.pslverr),    32'(m_err));
      chk("level",      32'(bus.level),      32'(m_lvl));
      chk("flag_empty", 32'(bus.flag_empty), 32'(m_lvl == 0));
      chk("flag_full",  32'(bus.flag_full),  32'(m_lvl == DEPTH));
      chk("rx_intr",    32'(bus.rx_intr),    32'(m_lvl >= WM));
      chk("overrun",    32'(bus.overrun),    32'(m_ovr));
      chk("rx_timeout", 32'(bus.rx_timeout), 32'(m_to));
    end
  end

  task automatic clk1();
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d, input bit oclr);
    bus.rx_valid = 1'b1; bus.rx_data = d; bus.overrun_clr = oclr;
    clk1();
    bus.rx_valid = 1'b0; bus.overrun_clr = 1'b0;
  endtask

  // Values captured on the cycle after the access phase and when pready is seen.
  int         r_lat;
  logic       r_err, r_rd1, r_wr1, r_ovr1, r_ff1, r_to1;
  logic [7:0] r_wd1;
  logic [31:0] r_lv1;

  task automatic apb_read(input bit inj, input logic [7:0] d);
    bus.psel = 1'b1; bus.pwrite = 1'b0; bus.penable = 1'b0; bus.rx_valid = 1'b0;
    clk1();
    bus.penable = 1'b1; bus.rx_valid = inj; bus.rx_data = d;
    clk1();
    bus.rx_valid = 1'b0;
    r_rd1 = bus.fifo_rd; r_wr1 = bus.fifo_wr; r_wd1 = bus.fifo_wdata;
    r_lv1 = 32'(bus.level); r_ovr1 = bus.overrun; r_ff1 = bus.flag_full; r_to1 = bus.rx_timeout;
    r_lat = 1;
    while (!bus.pready && r_lat < 8) begin
      clk1();
      r_lat++;
    end
    chk("pready_seen", 32'(bus.pready), 32'd1);
    r_err = bus.pslverr;
    bus.penable = 1'b0; bus.psel = 1'b0;
    clk1();
    chk("read_release", 32'({bus.pready, bus.pslverr}), 32'd0);
  endtask

  initial begin
    bus.rx_valid = 1'b0; bus.rx_data = '0; bus.psel = 1'b0; bus.penable = 1'b0;
    bus.pwrite = 1'b0; bus.overrun_clr = 1'b0;
    clr_b = 1'b0;
    repeat (2) clk1();
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_flags", 32'({bus.flag_empty, bus.flag_full, bus.rx_intr, bus.overrun}), 32'b1000);
    chk("rst_strobes", 32'({bus.fifo_wr, bus.fifo_rd, bus.pready, bus.pslverr, bus.rx_timeout}), 32'd0);
    clr_b = 1'b1;

    push(8'hA5, 1'b0);
    chk("push1", 32'({bus.fifo_wr, bus.fifo_wdata, bus.level}), {23'd0, 1'b1, 8'hA5, 3'd1});
    chk("push1_intr", 32'(bus.rx_intr), 32'd0);
    push(8'h3C, 1'b0);
    chk("push2", 32'({bus.fifo_wr, bus.fifo_wdata, bus.level}), {23'd0, 1'b1, 8'h3C, 3'd2});
    chk("push2_intr", 32'(bus.rx_intr), 32'd1);

    push(8'h01, 1'b0);
    push(8'h02, 1'b0);
    chk("full4", 32'({bus.level, bus.flag_full}), {28'd0, 3'd4, 1'b1});
    apb_read(1'b0, 8'h00);
    chk("rd_pulse", 32'(r_rd1), 32'd1);
    chk("rd_lat", 32'(r_lat), 32'd2);
    chk("rd_level", r_lv1, 32'd3);
    chk("rd_full_drop", 32'(r_ff1), 32'd0);
    chk("rd_err", 32'(r_err), 32'd0);

    push(8'h55, 1'b0);
    push(8'h11, 1'b0);
    chk("hold_park", 32'({bus.fifo_wr, bus.overrun, bus.level}), {28'd0, 1'b0, 1'b0, 3'd4});
    push(8'h22, 1'b0);
    chk("ovr_set", 32'({bus.fifo_wr, bus.overrun}), 32'b01);
    push(8'h33, 1'b1);
    chk("ovr_beats_clr", 32'(bus.overrun), 32'd1);
    bus.overrun_clr = 1'b1; clk1(); bus.overrun_clr = 1'b0;
    chk("ovr_clr", 32'(bus.overrun), 32'd0);
    apb_read(1'b0, 8'h00);
    chk("hold_drain", 32'({r_rd1, r_wr1, r_wd1}), {22'd0, 1'b1, 1'b1, 8'h11});
    chk("hold_level", r_lv1, 32'd4);

    apb_read(1'b1, 8'h44);
    chk("coinc_wr", 32'({r_rd1, r_wr1, r_wd1}), {22'd0, 1'b1, 1'b1, 8'h44});
    chk("coinc_level", r_lv1, 32'd4);
    chk("coinc_ovr", 32'(r_ovr1), 32'd0);

    repeat (4) apb_read(1'b0, 8'h00);
    chk("drained", 32'(bus.level), 32'd0);
    apb_read(1'b0, 8'h00);
    chk("empty_rd", 32'({r_rd1, r_err}), 32'b01);
    chk("empty_lat", 32'(r_lat), 32'd1);

    push(8'hB1, 1'b0); push(8'hB2, 1'b0); push(8'hB3, 1'b0);
    bus.psel = 1'b1; bus.penable = 1'b0; clk1();
    bus.penable = 1'b1; clk1();
    chk("pop_before_rst", 32'(bus.fifo_rd), 32'd1);
    clr_b = 1'b0; bus.psel = 1'b0; bus.penable = 1'b0;
    clk1();
    chk("rst_mid", 32'({bus.level, bus.pready, bus.fifo_rd, bus.flag_empty}), {26'd0, 3'd0, 1'b0, 1'b0, 1'b1});
    clr_b = 1'b1; clk1();
    apb_read(1'b0, 8'h00);
    chk("idle_after_rst", 32'(r_lat), 32'd1);

`ifdef SSP_RX_TIMEOUT_EN
    begin
      int k;
      push(8'h77, 1'b0);
      k = 0;
      while (!bus.rx_timeout && k < 40) begin
        clk1();
        k++;
      end
      chk("timeout_cycles", 32'(k), 32'd32);
      apb_read(1'b0, 8'h00);
      chk("timeout_clr", 32'(r_to1), 32'd0);
    end
`endif

    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 9))
        0, 1: apb_read(1'($urandom_range(0, 1)), 8'($urandom));
        2: begin
          bus.psel = 1'b1; bus.pwrite = 1'b1; bus.penable = 1'b0; clk1();
          bus.penable = 1'b1; bus.rx_valid = 1'($urandom_range(0, 1)); bus.rx_data = 8'($urandom);
          clk1();
          bus.rx_valid = 1'b0; bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        end
        3: begin
          if ($urandom_range(0, 9) == 0) begin
            clr_b = 1'b0; clk1(); clr_b = 1'b1;
          end else begin
            clk1();
          end
        end
        default: begin
          bus.rx_valid = ($urandom_range(0, 2) != 0);
          bus.rx_data = 8'($urandom);
          bus.overrun_clr = ($urandom_range(0, 7) == 0);
          clk1();
          bus.rx_valid = 1'b0; bus.overrun_clr = 1'b0;
        end
      endcase
    end
    repeat (3) clk1();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
